// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard hazard unit: RAW/WAW/branch/writeback-port stalls
// plus D- and E-stage forwarding selects for NSRC source operands.
module hazard_scoreboard #(
  parameter int REGW   = 5,
  parameter int NSRC   = 3,
  parameter int MAXLAT = 8,
  parameter int CNTW   = $clog2(MAXLAT + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NSRC*(REGW+2)-1:0] src_tag_d,
  input  logic [NSRC-1:0]          src_vld_d,
  input  logic [NSRC*(REGW+2)-1:0] src_tag_e,
  input  logic [NSRC-1:0]          src_vld_e,
  input  logic                     issue_vld,
  input  logic [REGW+1:0]          dst_tag_d,
  input  logic                     dst_vld_d,
  input  logic [CNTW-1:0]          lat_d,
  input  logic                     branch_d,
  input  logic [REGW+1:0]          wtag_e,
  input  logic [REGW+1:0]          wtag_m,
  input  logic [REGW+1:0]          wtag_w,
  input  logic                     wen_e,
  input  logic                     wen_m,
  input  logic                     wen_w,
  input  logic                     flush,
  input  logic                     stall_ext,
  output logic                     stall,
  output logic [NSRC*2-1:0]        fwd_d,
  output logic [NSRC*2-1:0]        fwd_e,
  output logic                     busy
);

  localparam int TW   = REGW + 2;
  localparam int IW   = REGW + 1;
  localparam int NENT = 2 ** IW;
  localparam int RSVW = MAXLAT + 2;
  localparam logic [CNTW-1:0] LMAX = CNTW'(MAXLAT);

  // Only banks 00/01 are tracked, and int r0 is hardwired so it never participates.
  function automatic logic tag_ok(input logic [TW-1:0] tag);
    return (tag[TW-1] == 1'b0) && (tag != '0);
  endfunction

  function automatic logic [IW-1:0] tag_idx(input logic [TW-1:0] tag);
    return tag[IW-1:0];
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic          vld,
    input logic [TW-1:0] tag,
    input logic [TW-1:0] tag_m,
    input logic          en_m,
    input logic [TW-1:0] tag_w,
    input logic          en_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (vld && tag_ok(tag)) begin
      if (en_m && (tag == tag_m)) begin
        sel = 2'b10;
      end else if (en_w && (tag == tag_w)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  logic [CNTW-1:0] cnt [NENT];
  logic [RSVW-1:0] rsv;
  logic [NENT-1:0] cnt_nz;

  logic [CNTW-1:0] lat_sat;
  logic [RSVW-1:0] rsv_sh;
  logic [CNTW-1:0] dst_cnt;
  logic [NSRC-1:0] src_busy;
  logic [NSRC-1:0] src_hit_e;
  logic            raw_stall;
  logic            br_stall;
  logic            waw_stall;
  logic            wb_stall;
  logic            issue;
  logic            load_en;
  logic [IW-1:0]   load_idx;

  always_comb begin
    lat_sat = (lat_d > LMAX) ? LMAX : lat_d;
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    logic [TW-1:0] td;
    logic [TW-1:0] te;

    always_comb begin
      td = src_tag_d[s*TW +: TW];
      te = src_tag_e[s*TW +: TW];
    end

    always_comb begin
      src_busy[s]  = src_vld_d[s] && tag_ok(td) && (cnt[tag_idx(td)] != '0);
      src_hit_e[s] = src_vld_d[s] && tag_ok(td) && wen_e && (td == wtag_e);
      fwd_d[2*s +: 2] = fwd_sel(src_vld_d[s], td, wtag_m, wen_m, wtag_w, wen_w);
      fwd_e[2*s +: 2] = fwd_sel(src_vld_e[s], te, wtag_m, wen_m, wtag_w, wen_w);
    end
  end

  always_comb begin
    dst_cnt   = tag_ok(dst_tag_d) ? cnt[tag_idx(dst_tag_d)] : '0;
    // rsv[L+1] via a shift so the index never overflows CNTW bits.
    rsv_sh    = rsv >> lat_sat;
    raw_stall = |src_busy;
    br_stall  = branch_d && (|src_hit_e);
    waw_stall = dst_vld_d && (dst_cnt > lat_sat);
    wb_stall  = dst_vld_d && rsv_sh[1];
    stall     = (issue_vld && (raw_stall || br_stall || waw_stall || wb_stall)) || stall_ext;
    issue     = issue_vld && !stall && !flush;
    load_en   = issue && dst_vld_d && (lat_sat != '0) && tag_ok(dst_tag_d);
    load_idx  = tag_idx(dst_tag_d);
    busy      = |cnt_nz;
  end

  for (genvar e = 0; e < NENT; e++) begin : g_cnt
    always_comb begin
      cnt_nz[e] = (cnt[e] != '0);
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        cnt[e] <= '0;
      end else if (load_en && (load_idx == IW'(e))) begin
        cnt[e] <= lat_sat;
      end else if (cnt_nz[e]) begin
        cnt[e] <= cnt[e] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsv <= '0;
    end else begin
      rsv <= (rsv >> 1) | ((issue && dst_vld_d) ? (RSVW'(1) << lat_sat) : '0);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  localparam int REGW   = 5;
  localparam int NSRC   = 3;
  localparam int MAXLAT = 8;
  localparam int CNTW   = 4;
  localparam int TW     = REGW + 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NSRC*TW-1:0]   src_tag_d;
  logic [NSRC-1:0]      src_vld_d;
  logic [NSRC*TW-1:0]   src_tag_e;
  logic [NSRC-1:0]      src_vld_e;
  logic                 issue_vld;
  logic [TW-1:0]        dst_tag_d;
  logic                 dst_vld_d;
  logic [CNTW-1:0]      lat_d;
  logic                 branch_d;
  logic [TW-1:0]        wtag_e;
  logic [TW-1:0]        wtag_m;
  logic [TW-1:0]        wtag_w;
  logic                 wen_e;
  logic                 wen_m;
  logic                 wen_w;
  logic                 flush;
  logic                 stall_ext;
  logic                 stall;
  logic [NSRC*2-1:0]    fwd_d;
  logic [NSRC*2-1:0]    fwd_e;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.REGW(REGW), .NSRC(NSRC), .MAXLAT(MAXLAT)) dut (
    .clk(clk), .rstn(rstn),
    .src_tag_d(src_tag_d), .src_vld_d(src_vld_d),
    .src_tag_e(src_tag_e), .src_vld_e(src_vld_e),
    .issue_vld(issue_vld), .dst_tag_d(dst_tag_d), .dst_vld_d(dst_vld_d),
    .lat_d(lat_d), .branch_d(branch_d),
    .wtag_e(wtag_e), .wtag_m(wtag_m), .wtag_w(wtag_w),
    .wen_e(wen_e), .wen_m(wen_m), .wen_w(wen_w),
    .flush(flush), .stall_ext(stall_ext),
    .stall(stall), .fwd_d(fwd_d), .fwd_e(fwd_e), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [TW-1:0] itag(input int n);
    return {2'b00, 5'(n)};
  endfunction

  function automatic logic [TW-1:0] ftag(input int n);
    return {2'b01, 5'(n)};
  endfunction

  task automatic idle();
    src_tag_d = '0; src_vld_d = '0; src_tag_e = '0; src_vld_e = '0;
    issue_vld = 1'b0; dst_tag_d = '0; dst_vld_d = 1'b0; lat_d = '0;
    branch_d = 1'b0; wtag_e = '0; wtag_m = '0; wtag_w = '0;
    wen_e = 1'b0; wen_m = 1'b0; wen_w = 1'b0; flush = 1'b0; stall_ext = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (12) step();
  endtask

  task automatic set_src_d(input int s, input logic [TW-1:0] t);
    src_tag_d[s*TW +: TW] = t;
    src_vld_d[s] = 1'b1;
  endtask

  task automatic set_src_e(input int s, input logic [TW-1:0] t);
    src_tag_e[s*TW +: TW] = t;
    src_vld_e[s] = 1'b1;
  endtask

  task automatic issue_op(input logic [TW-1:0] dst, input logic [CNTW-1:0] lat);
    idle();
    issue_vld = 1'b1; dst_tag_d = dst; dst_vld_d = 1'b1; lat_d = lat;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    repeat (2) step();
    #1;
    checks++;
    if ({stall, busy, fwd_d, fwd_e} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b busy=%b fwd_d=%b fwd_e=%b expected all 0",
               stall, busy, fwd_d, fwd_e);
    end
    rstn = 1'b1;
    issue_op(ftag(1), 4'd6);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: busy=%b expected 1", busy);
    end
    rstn = 1'b0;
    issue_vld = 1'b1;
    set_src_d(0, ftag(1));
    repeat (2) step();
    rstn = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears: stall=%b busy=%b expected 0 0", stall, busy);
    end
  endtask

  task automatic test_load_use();
    drain();
    issue_op(itag(5), 4'd1);
    issue_vld = 1'b1; set_src_d(0, itag(5)); dst_tag_d = itag(6); dst_vld_d = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b busy=%b expected 1 1", stall, busy);
    end
    step();
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: stall=%b expected 0", stall);
    end
    step();
    idle();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL load_use_busy: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fpu();
    int nstall;
    drain();
    issue_op(ftag(3), 4'd4);
    issue_vld = 1'b1; set_src_d(1, ftag(3)); dst_tag_d = ftag(4); dst_vld_d = 1'b1;
    nstall = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall === 1'b1 && busy === 1'b1) nstall++;
      step();
    end
    checks++;
    if (nstall != 4) begin
      errors++;
      $display("FAIL fpu_stall_cycles: stalled_with_busy=%0d expected 4", nstall);
    end
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fpu_release: stall=%b busy=%b expected 0 0", stall, busy);
    end
    step();
    idle();
  endtask

  task automatic test_forwarding();
    drain();
    set_src_e(0, itag(7));
    wtag_m = itag(7); wen_m = 1'b1; wtag_w = itag(7); wen_w = 1'b1;
    #1;
    checks++;
    if (fwd_e !== 6'b000010) begin
      errors++;
      $display("FAIL fwd_m_priority: fwd_e=%b expected 000010", fwd_e);
    end
    wen_m = 1'b0;
    #1;
    checks++;
    if (fwd_e !== 6'b000001) begin
      errors++;
      $display("FAIL fwd_w_only: fwd_e=%b expected 000001", fwd_e);
    end
    set_src_e(1, itag(0));
    wtag_m = itag(0); wen_m = 1'b1; wtag_w = itag(0); wen_w = 1'b1;
    #1;
    checks++;
    if (fwd_e !== 6'b000000) begin
      errors++;
      $display("FAIL fwd_r0: fwd_e=%b expected 000000", fwd_e);
    end
    set_src_d(2, ftag(7));
    wtag_m = itag(7); wen_m = 1'b1; wtag_w = ftag(7); wen_w = 1'b1;
    #1;
    checks++;
    if (fwd_d !== 6'b010000 || fwd_e !== 6'b000010) begin
      errors++;
      $display("FAIL fwd_bank: fwd_d=%b fwd_e=%b expected 010000 000010", fwd_d, fwd_e);
    end
    idle();
    set_src_d(0, {2'b10, 5'd7});
    set_src_e(2, itag(4));
    src_vld_e[2] = 1'b0;
    wtag_m = {2'b10, 5'd7}; wen_m = 1'b1; wtag_w = itag(4); wen_w = 1'b1;
    #1;
    checks++;
    if (fwd_d !== 6'b000000 || fwd_e !== 6'b000000) begin
      errors++;
      $display("FAIL fwd_invalid: fwd_d=%b fwd_e=%b expected 000000 000000", fwd_d, fwd_e);
    end
    idle();
  endtask

  task automatic test_branch();
    drain();
    issue_vld = 1'b1; branch_d = 1'b1; set_src_d(0, itag(9));
    wtag_e = itag(9); wen_e = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL br_stall: stall=%b expected 1", stall);
    end
    wen_e = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL br_no_wen: stall=%b expected 0", stall);
    end
    wen_e = 1'b1; branch_d = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL br_not_branch: stall=%b expected 0", stall);
    end
    branch_d = 1'b1; issue_vld = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL br_no_issue: stall=%b expected 0", stall);
    end
    stall_ext = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_ext: stall=%b expected 1", stall);
    end
    idle();
  endtask

  task automatic test_wb_conflict();
    drain();
    issue_op(itag(10), 4'd3);
    issue_vld = 1'b1; dst_tag_d = itag(11); dst_vld_d = 1'b1; lat_d = 4'd2;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL wb_clash: stall=%b expected 1", stall);
    end
    step();
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL wb_release: stall=%b expected 0", stall);
    end
    step();
    idle();
  endtask

  task automatic test_waw_flush();
    int nstall;
    drain();
    issue_op(ftag(2), 4'd5);
    issue_vld = 1'b1; dst_tag_d = ftag(2); dst_vld_d = 1'b1; lat_d = 4'd1;
    nstall = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (stall === 1'b1) nstall++;
      step();
    end
    checks++;
    if (nstall != 4) begin
      errors++;
      $display("FAIL waw_stall_cycles: stalled=%0d expected 4", nstall);
    end
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL waw_release: stall=%b expected 0", stall);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_stall: stall=%b expected 0", stall);
    end
    step();
    idle();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_load: busy=%b expected 0", busy);
    end
    issue_op(ftag(2), 4'd1);
    issue_vld = 1'b1; set_src_d(2, ftag(2));
    #1;
    checks++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL noflush_load: busy=%b stall=%b expected 1 1", busy, stall);
    end
    step();
    idle();
  endtask

  task automatic test_saturate();
    int nstall;
    drain();
    issue_op(ftag(9), 4'd15);
    issue_vld = 1'b1; set_src_d(0, ftag(9));
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall !== 1'b1) break;
      nstall++;
      step();
    end
    checks++;
    if (nstall != MAXLAT) begin
      errors++;
      $display("FAIL lat_saturate: stalled=%0d expected %0d", nstall, MAXLAT);
    end
    step();
    idle();
  endtask

  task automatic test_r0();
    drain();
    issue_op(itag(0), 4'd3);
    issue_vld = 1'b1; set_src_d(1, itag(0));
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_untracked: busy=%b stall=%b expected 0 0", busy, stall);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int nstall;
    drain();
    nstall = 0;
    for (int i = 1; i <= 3; i++) begin
      idle();
      issue_vld = 1'b1; dst_tag_d = itag(i); dst_vld_d = 1'b1; lat_d = 4'd0;
      if (i == 3) set_src_d(0, itag(1));
      #1;
      if (stall !== 1'b0) nstall++;
      step();
    end
    idle();
    #1;
    checks++;
    if (nstall != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_alu: stalled=%0d busy=%b expected 0 0", nstall, busy);
    end
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    test_reset();
    test_load_use();
    test_fpu();
    test_forwarding();
    test_branch();
    test_wb_conflict();
    test_waw_flush();
    test_saturate();
    test_r0();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
